// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory target for the CPU memory stage.
// A valid/ready request channel feeds a single-ported, byte-writable word
// array; each accepted request yields one response after a fixed latency.
// At most one transaction is in flight; a new request can be taken in the
// same cycle the current response is consumed.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so the range limit is representable even when the array
  // covers the whole address space.
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH_WORDS);
  // WAIT burns LATENCY-2 extra cycles; the acceptance edge and the
  // WAIT->RESP edge account for the other two.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              addr_err;
  logic              accept;

  assign word_idx   = req_addr[ADDR_W-1:2];
  assign mem_idx    = word_idx[IDX_W-1:0];
  assign addr_err   = (req_addr[1:0] != 2'b00) || ({1'b0, word_idx} >= DEPTH_LIM);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  // Ready is high in IDLE, passes resp_ready through in RESP, low in WAIT.
  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  // Transaction FSM and response registers; reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      state      <= (LATENCY == 1) ? RESP : WAIT;
      cnt        <= CNT_INIT;
      resp_err   <= addr_err;
      resp_rdata <= (!addr_err && !req_we) ? mem[mem_idx] : 32'h0;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  // Array write at the acceptance edge; no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (LATENCY 2, 1, 4) sharing
// clock and reset. Expected responses come from a small word model and are
// queued when a request is driven, then popped when the response appears.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]       req_valid, req_we, resp_ready;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [2:0][3:0]  req_be;
  wire  [2:0]       req_ready, resp_valid, resp_err;
  wire  [2:0][31:0] resp_rdata;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_W(32)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_W(32)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .ADDR_W(32)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]));

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Expected {err, rdata} for a request; applies stores to the model.
  function automatic logic [32:0] expect_of(input int u, input logic we, input logic [31:0] addr,
                                            input logic [31:0] wdata, input logic [3:0] be);
    int key;
    logic [31:0] w;
    key = u * 4096 + int'(addr[31:2]);
    if (addr[1:0] != 2'b00 || addr[31:2] >= 30'd1024) return {1'b1, 32'h0};
    if (we) begin
      w = model.exists(key) ? model[key] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model[key] = w;
      return {1'b0, 32'h0};
    end
    return {1'b0, (model.exists(key) ? model[key] : 32'h0)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one request with resp_ready high and collect its response.
  task automatic do_req(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input string name, output logic [31:0] got);
    logic [32:0] exp;
    int n;
    got = 32'h0;
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
    req_wdata[u] = wdata; req_be[u] = be; resp_ready[u] = 1'b1;
    #1;
    checks++;
    if (req_ready[u] !== 1'b1) begin
      failures++; $display("FAIL %s_ready: got=%b want=1", name, req_ready[u]);
    end
    sb.push_back(expect_of(u, we, addr, wdata, be));
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    n = 1;
    while (resp_valid[u] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    exp = sb.pop_front();
    checks++;
    if (resp_valid[u] !== 1'b1 || n != lat_of(u)) begin
      failures++; $display("FAIL %s_latency: got=%0d valid=%b want=%0d", name, n, resp_valid[u], lat_of(u));
    end
    checks++;
    if ({resp_err[u], resp_rdata[u]} !== exp) begin
      failures++; $display("FAIL %s_data: got err=%b data=%h want err=%b data=%h",
                           name, resp_err[u], resp_rdata[u], exp[32], exp[31:0]);
    end
    got = resp_rdata[u];
    tick();
    checks++;
    if (resp_valid[u] !== 1'b0) begin
      failures++; $display("FAIL %s_release: resp_valid got=%b want=0", name, resp_valid[u]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_we = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    tick(); tick();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({req_ready[u], resp_valid[u], resp_err[u], resp_rdata[u]} !== {3'b100, 32'h0}) begin
        failures++; $display("FAIL reset_state_%0d: got rdy=%b vld=%b err=%b data=%h want 1 0 0 0",
                             u, req_ready[u], resp_valid[u], resp_err[u], resp_rdata[u]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "st_10", got);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "ld_10", got);
    checks++;
    if (got !== 32'hDEADBEEF) begin
      failures++; $display("FAIL ld_10_value: got=%h want=deadbeef", got);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] got;
    do_req(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, "st_lane1", got);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "ld_lane1", got);
    checks++;
    if (got !== 32'hDEADABEF) begin
      failures++; $display("FAIL lane1_value: got=%h want=deadabef", got);
    end
    do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "st_be0", got);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "ld_be0", got);
    checks++;
    if (got !== 32'hDEADABEF) begin
      failures++; $display("FAIL be0_value: got=%h want=deadabef", got);
    end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_req(0, 1'b1, 32'h13, 32'h11111111, 4'b1111, "st_misalign", got);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "ld_after_err", got);
    checks++;
    if (got !== 32'hDEADABEF) begin
      failures++; $display("FAIL misalign_nowrite: got=%h want=deadabef", got);
    end
    do_req(0, 1'b0, 32'h1000, 32'h0, 4'b0000, "ld_range", got);
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    logic [31:0] got;
    int n;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; resp_ready[0] = 1'b0;
    sb.push_back(expect_of(0, 1'b0, 32'h10, 32'h0, 4'b0000));
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin tick(); n++; end
    exp = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
      req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'b1111; resp_ready[0] = 1'b0;
      #1;
      checks++;
      if (resp_valid[0] !== 1'b1) begin
        failures++; $display("FAIL bp_valid_%0d: got=%b want=1", c, resp_valid[0]);
      end
      checks++;
      if (req_ready[0] !== 1'b0) begin
        failures++; $display("FAIL bp_ready_%0d: got=%b want=0", c, req_ready[0]);
      end
      checks++;
      if ({resp_err[0], resp_rdata[0]} !== exp) begin
        failures++; $display("FAIL bp_data_%0d: got err=%b data=%h want err=%b data=%h",
                             c, resp_err[0], resp_rdata[0], exp[32], exp[31:0]);
      end
      tick();
    end
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL bp_passthru: req_ready got=%b want=1", req_ready[0]);
    end
    tick();
    checks++;
    if (resp_valid[0] !== 1'b0) begin
      failures++; $display("FAIL bp_release: resp_valid got=%b want=0", resp_valid[0]);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "ld_after_bp", got);
    checks++;
    if (got !== 32'hDEADABEF) begin
      failures++; $display("FAIL bp_not_consumed: got=%h want=deadabef", got);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; resp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin tick(); n++; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready[0], resp_valid[0], resp_err[0]} !== 3'b100) begin
      failures++; $display("FAIL reset_async: got rdy=%b vld=%b err=%b want 1 0 0",
                           req_ready[0], resp_valid[0], resp_err[0]);
    end
    @(posedge clk); #1;
    reset = 1'b0; resp_ready[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (resp_valid[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL reset_spurious: got=%0d responses want=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic [32:0] exp;
    for (int i = 0; i < 4; i++)
      do_req(1, 1'b1, 32'h40 + 32'(4 * i), 32'hA0000001 + 32'(i * 32'h01010101), 4'b1111, "b2b_st", got);
    resp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h40 + 32'(4 * i);
        sb.push_back(expect_of(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'b0000));
      end else begin
        req_valid[1] = 1'b0;
      end
      #1;
      if (i > 0) begin
        exp = sb.pop_front();
        checks++;
        if (resp_valid[1] !== 1'b1 || {resp_err[1], resp_rdata[1]} !== exp) begin
          failures++; $display("FAIL b2b_resp_%0d: got vld=%b err=%b data=%h want vld=1 err=%b data=%h",
                               i - 1, resp_valid[1], resp_err[1], resp_rdata[1], exp[32], exp[31:0]);
        end
      end
      if (i < 4) begin
        checks++;
        if (req_ready[1] !== 1'b1) begin
          failures++; $display("FAIL b2b_ready_%0d: got=%b want=1", i, req_ready[1]);
        end
      end
      tick();
    end
    checks++;
    if (resp_valid[1] !== 1'b0) begin
      failures++; $display("FAIL b2b_release: resp_valid got=%b want=0", resp_valid[1]);
    end
  endtask

  task automatic test_reset_wait();
    logic [32:0] exp;
    logic [31:0] got;
    int seen;
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
    req_wdata[2] = 32'h12345678; req_be[2] = 4'b1111; resp_ready[2] = 1'b1;
    exp = expect_of(2, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    tick();
    req_valid[2] = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready[2], resp_valid[2]} !== 2'b10 || exp[32] !== 1'b0) begin
      failures++; $display("FAIL rstwait_async: got rdy=%b vld=%b want 1 0", req_ready[2], resp_valid[2]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (resp_valid[2] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rstwait_dropped: got=%0d responses want=0", seen);
    end
    do_req(2, 1'b0, 32'h20, 32'h0, 4'b0000, "rstwait_ld", got);
    checks++;
    if (got !== 32'h12345678) begin
      failures++; $display("FAIL rstwait_committed: got=%h want=12345678", got);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder that services load/store requests issued by the CPU memory stage over a valid/ready request channel and a valid/ready response channel. It holds a single-ported word array with per-byte write enables, a programmable fixed response latency and alignment/range error reporting. It is the target side of the memory-stage data interface and sits between the `memory` stage and the data storage. It accepts at most one outstanding transaction at a time.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`; legal range 1..15.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept the request this cycle.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, lane i = bits [8i+7:8i].
- `req_be`  in  4: store byte enables; ignored for loads.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: requester takes the response this cycle.
- `resp_rdata`  out  32: load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned or out-of-range access.

## Operation
- Word index = `req_addr[ADDR_W-1:2]`.
- Error when `req_addr[1:0] != 0` or word index >= `DEPTH_WORDS`.
- Acceptance: `req_valid && req_ready` at a rising edge.
- On acceptance:
  - Store without error: write each lane whose `req_be` bit is set. `req_be == 0` writes nothing but still returns a response.
  - Load without error: capture the full array word into the response data register.
  - Error: no array write; response data = 0, `resp_err` = 1.
  - Store response: `resp_rdata` = 0, `resp_err` = 0 unless the access is an error.
- FSM states:
  - IDLE: `req_ready` = 1. On acceptance, go to RESP if `LATENCY` == 1. Otherwise go to WAIT and load the counter with `LATENCY` - 2.
  - WAIT: the counter decrements every cycle. When it reaches 0, go to RESP.
  - RESP: `resp_valid` = 1. `req_ready` = `resp_ready` (combinational pass-through).
    - On `resp_ready` with a new acceptance in the same cycle: handle that request as from IDLE.
    - On `resp_ready` with no acceptance: go to IDLE.
    - Otherwise stay in RESP.
- `req_ready` = 0 in WAIT.
- The array has no reset. Contents persist across `reset`, and reading a never-written word returns undefined data.
- Same-address store followed by load: the load returns the updated data, because the write commits at the acceptance edge.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0.
- Request accepted at edge k → `resp_valid` rises after edge k+`LATENCY`-1 (LATENCY=1: visible in the cycle right after acceptance).
- While `resp_valid` = 1 and `resp_ready` = 0, `resp_rdata` and `resp_err` stay stable.
- Maximum throughput is one transaction per `LATENCY` cycles; with LATENCY=1 and `resp_ready` held at 1, that is one per cycle.
- Reset asserted mid-transaction:
  - The outstanding response is dropped and never presented.
  - A store already accepted remains committed.
  - The FSM returns to IDLE immediately (asynchronous).
- Request inputs are sampled only when `req_ready` = 1. `req_valid` while not ready is legal and is not consumed.

## Test plan
- Reset: assert `reset` mid-cycle → immediately `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0; after deassert, no spurious response.
- Store/load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 with be=4'b1111 accepted at edge k → ack (`resp_valid` = 1, `resp_rdata` = 0, `resp_err` = 0) after edge k+1.
  - Load from 0x10 → 0xDEADBEEF exactly 2 edges after acceptance.
- Byte lanes: after the previous case, store 0x0000AB00 to 0x10 with be=4'b0010, then load 0x10 → 0xDEADABEF. A store with be=0 leaves the word unchanged.
- Errors:
  - Store to 0x13 → `resp_err` = 1 and word 0x10 unchanged.
  - Load from 0x1000 (index 1024, DEPTH_WORDS=1024) → `resp_err` = 1, `resp_rdata` = 0.
- Backpressure and throughput:
  - Hold `resp_ready` = 0 for 3 cycles in RESP → response stable, `req_ready` = 0, pending `req_valid` not consumed.
  - With LATENCY=1 and `resp_ready` = 1, four back-to-back loads → four responses on four consecutive cycles, in order.
- Reset during WAIT (LATENCY=4): store 0x12345678 to 0x20, then assert `reset` one cycle after acceptance → no response appears; a later load of 0x20 returns 0x12345678.
